doc_uart_sender: RTL

DOC_UART_SENDER -- requirements
Module: doc_uart_sender

---
 rtl/doc_uart_sender.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/doc_uart_sender.sv
// Streams a ROWS x COLS character document out of a UART (8N1), appending CR LF per row.
// A rising edge on send_start launches one transfer; done pulses once after the final stop bit.
// The document read port is owned (read_enable high) for the whole transfer.
module doc_uart_sender #(
  parameter int CLKS_PER_BIT = 217,
  parameter int ROWS         = 15,
  parameter int COLS         = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_start,
  output logic       read_enable,
  output logic [8:0] read_addr,
  input  logic [7:0] read_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    COLS_W    = 5'(COLS);
  localparam logic [3:0]    ROWS_W    = 4'(ROWS);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, NEXT, DONE} state_t;
  typedef enum logic [1:0] {SEL_CHAR, SEL_CR, SEL_LF} sel_t;

  state_t        state_q;
  sel_t          sel_q;
  logic          start_q;   // previous send_start level for edge detection
  logic          arm_q;     // set once send_start has been seen low after reset
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [3:0]    row_q;
  logic [4:0]    col_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          re_q;

  logic          start_rise;
  logic          baud_end;
  logic [7:0]    fetch_byte;
  logic [4:0]    col_d;
  logic [3:0]    row_d;

  // Edge detect, bit-period end, blank substitution for control codes, position increments
  always_comb begin
    start_rise = send_start & ~start_q & arm_q;
    baud_end   = (baud_q == BAUD_LAST);
    fetch_byte = (read_data < 8'h20) ? 8'h20 : read_data;
    col_d      = col_q + 5'd1;
    row_d      = row_q + 4'd1;
  end

  // Transfer FSM with registered outputs; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_CHAR;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      row_q   <= 4'd0;
      col_q   <= 5'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      start_q <= send_start;
      if (!send_start) arm_q <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_q <= FETCH;
            row_q   <= 4'd0;
            col_q   <= 5'd0;
            re_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          shift_q <= fetch_byte;
          sel_q   <= SEL_CHAR;
          baud_q  <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= NEXT;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        NEXT: begin
          case (sel_q)
            SEL_CHAR: begin
              col_q <= col_d;
              if (col_d == COLS_W) begin
                shift_q <= 8'h0D;
                sel_q   <= SEL_CR;
                tx_q    <= 1'b0;
                state_q <= START;
              end else begin
                state_q <= FETCH;
              end
            end
            SEL_CR: begin
              shift_q <= 8'h0A;
              sel_q   <= SEL_LF;
              tx_q    <= 1'b0;
              state_q <= START;
            end
            default: begin
              col_q <= 5'd0;
              row_q <= row_d;
              sel_q <= SEL_CHAR;
              if (row_d == ROWS_W) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                state_q <= FETCH;
              end
            end
          endcase
        end
        DONE: begin
          busy_q  <= 1'b0;
          re_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address is only presented while the read port is owned
  always_comb begin
    read_addr = re_q ? {row_q, col_q} : 9'd0;
  end

  assign read_enable = re_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
